// File: rtl/ram_dma.sv
// ram_dma: word-granular block copy engine on the data-RAM master port.
// It copies len words from src to dst, ascending, with a read and then a write
// for each word, and arbitrates for the RAM port through a req/gnt handshake.
// Optional feature macro DMA_FILL_EN: adds a fill mode that writes a constant
// word to every destination location and never reads the source.
module ram_dma #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  len_i,
`ifdef DMA_FILL_EN
  input  logic              fill_i,
  input  logic [DATA_W-1:0] fill_data_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              req_o,
  input  logic              gnt_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] data_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              err_q, err_d;
  logic              misaligned;
`ifdef DMA_FILL_EN
  logic              fill_q, fill_d;
`endif

  // A start is rejected when an address it will actually use is not word aligned.
  always_comb begin
`ifdef DMA_FILL_EN
    misaligned = (fill_i ? 1'b0 : (|src_addr_i[1:0])) | (|dst_addr_i[1:0]);
`else
    misaligned = (|src_addr_i[1:0]) | (|dst_addr_i[1:0]);
`endif
  end

  // State register and datapath registers.
  // NOTE: the buffer and pointers are reset too, so the bus outputs start at a known zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
`ifdef DMA_FILL_EN
      fill_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
`ifdef DMA_FILL_EN
      fill_q  <= fill_d;
`endif
    end
  end

  // Next-state logic: start/abort handling, per-word read/write sequencing.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    err_d   = 1'b0;
`ifdef DMA_FILL_EN
    fill_d  = fill_q;
`endif

    case (state_q)
      IDLE: begin
        // Abort wins over start while idle: neither has any effect.
        if (start_i && !abort_i) begin
          if (misaligned) begin
            err_d = 1'b1;
          end else if (len_i == '0) begin
            state_d = DONE;
          end else begin
            src_d   = src_addr_i;
            dst_d   = dst_addr_i;
            cnt_d   = len_i;
`ifdef DMA_FILL_EN
            fill_d  = fill_i;
            if (fill_i) begin
              buf_d   = fill_data_i;
              state_d = WR;
            end else begin
              state_d = RD;
            end
`else
            state_d = RD;
`endif
          end
        end
      end

      RD: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (gnt_i) begin
          buf_d   = data_i;
          state_d = WR;
        end
      end

      WR: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (gnt_i) begin
          src_d = src_q + ADDR_W'(4);
          dst_d = dst_q + ADDR_W'(4);
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = DONE;
          end else begin
`ifdef DMA_FILL_EN
            state_d = fill_q ? WR : RD;
`else
            state_d = RD;
`endif
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus and status outputs decoded from the current state; they hold while ungranted.
  always_comb begin
    busy_o = (state_q != IDLE);
    done_o = (state_q == DONE);
    err_o  = err_q;
    req_o  = 1'b0;
    we_o   = 1'b0;
    addr_o = '0;
    data_o = '0;
    case (state_q)
      RD: begin
        req_o  = 1'b1;
        addr_o = src_q;
      end
      WR: begin
        req_o  = 1'b1;
        we_o   = 1'b1;
        addr_o = dst_q;
        data_o = buf_q;
      end
      default: begin
        req_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_dma.sv
// tb_ram_dma: directed bench for ram_dma with a behavioural RAM and an
// expected-access queue built from the copy/fill rules.
module tb_ram_dma;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        abort_i;
  logic [31:0] src_addr_i;
  logic [31:0] dst_addr_i;
  logic [15:0] len_i;
`ifdef DMA_FILL_EN
  logic        fill_i;
  logic [31:0] fill_data_i;
`endif
  logic        busy_o, done_o, err_o, req_o, gnt_i, we_o;
  logic [31:0] addr_o, data_o, data_i;

  ram_dma dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .len_i      (len_i),
`ifdef DMA_FILL_EN
    .fill_i     (fill_i),
    .fill_data_i(fill_data_i),
`endif
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .req_o      (req_o),
    .gnt_i      (gnt_i),
    .we_o       (we_o),
    .addr_o     (addr_o),
    .data_o     (data_o),
    .data_i     (data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RAM seen by the DUT, and the bench's own idea of what it should contain.
  logic [31:0] mem   [0:1023];
  logic [31:0] model [0:1023];

  function automatic logic [31:0] pat(input int i);
    return 32'h1000_0000 + i * 32'h0001_0003;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'h3FF);
  endfunction

  assign data_i = mem[addr_o[11:2]];

  always @(posedge clk) begin
    if (req_o && gnt_i && we_o) mem[addr_o[11:2]] <= data_o;
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  acc_t exp_q[$];
  int   req_seen = 0;

  task automatic expect_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
    for (int i = 0; i < n; i++) begin
      acc_t a;
      a.we = 1'b0; a.addr = src + 32'(4 * i); a.data = '0;
      exp_q.push_back(a);
      a.we = 1'b1; a.addr = dst + 32'(4 * i); a.data = model[widx(src + 32'(4 * i))];
      model[widx(a.addr)] = a.data;
      exp_q.push_back(a);
    end
  endtask

  task automatic expect_read(input logic [31:0] addr);
    acc_t a;
    a.we = 1'b0; a.addr = addr; a.data = '0;
    exp_q.push_back(a);
  endtask

  task automatic expect_fill(input logic [31:0] dst, input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) begin
      acc_t a;
      a.we = 1'b1; a.addr = dst + 32'(4 * i); a.data = d;
      model[widx(a.addr)] = d;
      exp_q.push_back(a);
    end
  endtask

  // Cycle-by-cycle bus checker: granted accesses must match the expected queue in order,
  // stalled requests must present the pending access, and writes require a request.
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      if (we_o) check("we_needs_req", {63'd0, req_o}, 64'd1);
      if (req_o) req_seen++;
      if (req_o && exp_q.size() > 0) begin
        check("acc_we", {63'd0, we_o}, {63'd0, exp_q[0].we});
        check("acc_addr", {32'd0, addr_o}, {32'd0, exp_q[0].addr});
        if (exp_q[0].we) check("acc_data", {32'd0, data_o}, {32'd0, exp_q[0].data});
        if (gnt_i) void'(exp_q.pop_front());
      end else if (req_o && gnt_i) begin
        check("unexpected_access", {32'd0, addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end
    end
  end

  // Results of the last run.
  int r_done_cyc, r_n_done, r_err_cyc, r_n_err, r_busy_cnt;
  bit busy_log [0:63];

  // Start a transfer at cycle 0 and watch ncyc cycles; cycle k is k clock edges after the start edge.
  task automatic run(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len,
                     input bit fill, input logic [31:0] fdata,
                     input int stall_at, input int stall_len, input int abort_at,
                     input int restart_at, input int ncyc);
    @(negedge clk);
    src_addr_i = src; dst_addr_i = dst; len_i = len;
`ifdef DMA_FILL_EN
    fill_i = fill; fill_data_i = fdata;
`else
    if (fill) $display("note: fill run requested without fill support, data %0h", fdata);
`endif
    start_i = 1'b1;
    abort_i = (abort_at == 0);
    gnt_i   = 1'b1;
    r_done_cyc = -1; r_n_done = 0; r_err_cyc = -1; r_n_err = 0; r_busy_cnt = 0;
    for (int i = 0; i < 64; i++) busy_log[i] = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      start_i = (k == restart_at);
      if (k == restart_at) begin
        src_addr_i = 32'h104; dst_addr_i = 32'h3F0; len_i = 16'd7;
      end
      gnt_i   = !(k >= stall_at && k < stall_at + stall_len);
      abort_i = (k == abort_at);
      if (done_o) begin
        r_n_done++;
        if (r_done_cyc < 0) r_done_cyc = k;
      end
      if (err_o) begin
        r_n_err++;
        if (r_err_cyc < 0) r_err_cyc = k;
      end
      if (busy_o) r_busy_cnt++;
      if (k < 64) busy_log[k] = busy_o;
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    gnt_i   = 1'b1;
  endtask

  int req_before;

  initial begin
    rst = 1'b0; start_i = 1'b0; abort_i = 1'b0; gnt_i = 1'b1;
    src_addr_i = '0; dst_addr_i = '0; len_i = '0;
`ifdef DMA_FILL_EN
    fill_i = 1'b0; fill_data_i = '0;
`endif
    for (int i = 0; i < 1024; i++) begin
      mem[i]   = pat(i);
      model[i] = pat(i);
    end
    #12;
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_req",  {63'd0, req_o},  64'd0);
    check("rst_we",   {63'd0, we_o},   64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_err",  {63'd0, err_o},  64'd0);
    check("rst_addr", {32'd0, addr_o}, 64'd0);
    check("rst_data", {32'd0, data_o}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic copy, with a start pulse while busy that must be ignored.
    expect_copy(32'h100, 32'h200, 4);
    run(32'h100, 32'h200, 16'd4, 1'b0, 32'h0, 99, 0, 99, 2, 12);
    check("copy_done_cyc", 64'(r_done_cyc), 64'd9);
    check("copy_done_cnt", 64'(r_n_done), 64'd1);
    check("copy_busy_cnt", 64'(r_busy_cnt), 64'd9);
    check("copy_q_empty", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 4; i++) check("copy_mem", {32'd0, mem[widx(32'h200) + i]}, {32'd0, model[widx(32'h200) + i]});
    check("copy_lit0", {32'd0, mem[32'h80]}, 64'h104000C0);
    check("copy_lit3", {32'd0, mem[32'h83]}, 64'h104300C9);
    check("copy_ignored_restart", {32'd0, mem[widx(32'h3F0)]}, {32'd0, pat(widx(32'h3F0))});

    // Grant withheld for 3 cycles during the second read.
    expect_copy(32'h500, 32'h600, 4);
    run(32'h500, 32'h600, 16'd4, 1'b0, 32'h0, 3, 3, 99, 99, 15);
    check("stall_done_cyc", 64'(r_done_cyc), 64'd12);
    check("stall_q_empty", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 4; i++) check("stall_mem", {32'd0, mem[widx(32'h600) + i]}, {32'd0, model[widx(32'h600) + i]});

    // Zero length: immediate done, no bus traffic.
    req_before = req_seen;
    run(32'h100, 32'h200, 16'd0, 1'b0, 32'h0, 99, 0, 99, 99, 4);
    check("len0_done_cyc", 64'(r_done_cyc), 64'd1);
    check("len0_done_cnt", 64'(r_n_done), 64'd1);
    check("len0_no_req", 64'(req_seen - req_before), 64'd0);

    // Misaligned source: error pulse, never busy.
    req_before = req_seen;
    run(32'h102, 32'h200, 16'd4, 1'b0, 32'h0, 99, 0, 99, 99, 4);
    check("misal_err_cyc", 64'(r_err_cyc), 64'd1);
    check("misal_err_cnt", 64'(r_n_err), 64'd1);
    check("misal_busy", 64'(r_busy_cnt), 64'd0);
    check("misal_no_done", 64'(r_n_done), 64'd0);
    check("misal_no_req", 64'(req_seen - req_before), 64'd0);

    // Abort together with start in idle: nothing happens.
    run(32'h100, 32'h200, 16'd4, 1'b0, 32'h0, 99, 0, 0, 99, 4);
    check("abort_start_busy", 64'(r_busy_cnt), 64'd0);
    check("abort_start_err", 64'(r_n_err), 64'd0);

    // Abort after the second write of an 8-word copy; the read granted on the abort cycle completes.
    expect_copy(32'h300, 32'h400, 2);
    expect_read(32'h308);
    run(32'h300, 32'h400, 16'd8, 1'b0, 32'h0, 99, 0, 5, 99, 20);
    check("abort_busy5", {63'd0, busy_log[5]}, 64'd1);
    check("abort_busy6", {63'd0, busy_log[6]}, 64'd0);
    check("abort_no_done", 64'(r_n_done), 64'd0);
    check("abort_q_empty", 64'(exp_q.size()), 64'd0);
    check("abort_w0", {32'd0, mem[widx(32'h400)]}, {32'd0, pat(widx(32'h300))});
    check("abort_w1", {32'd0, mem[widx(32'h404)]}, {32'd0, pat(widx(32'h304))});
    check("abort_w2_untouched", {32'd0, mem[widx(32'h408)]}, {32'd0, pat(widx(32'h408))});

    // Fresh start after abort runs normally.
    expect_copy(32'h800, 32'h880, 2);
    run(32'h800, 32'h880, 16'd2, 1'b0, 32'h0, 99, 0, 99, 99, 8);
    check("after_abort_done", 64'(r_done_cyc), 64'd5);
    check("after_abort_q", 64'(exp_q.size()), 64'd0);
    check("after_abort_mem", {32'd0, mem[widx(32'h884)]}, {32'd0, pat(widx(32'h804))});

    // Asynchronous reset in the middle of a transfer.
    expect_copy(32'h700, 32'h780, 1);
    expect_read(32'h704);
    @(negedge clk);
    src_addr_i = 32'h700; dst_addr_i = 32'h780; len_i = 16'd4; start_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    #3 rst = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy_o}, 64'd0);
    check("arst_req",  {63'd0, req_o},  64'd0);
    check("arst_we",   {63'd0, we_o},   64'd0);
    check("arst_addr", {32'd0, addr_o}, 64'd0);
    check("arst_data", {32'd0, data_o}, 64'd0);
    check("arst_q", 64'(exp_q.size()), 64'd0);
    check("arst_w0", {32'd0, mem[widx(32'h780)]}, {32'd0, pat(widx(32'h700))});
    check("arst_w1_untouched", {32'd0, mem[widx(32'h784)]}, {32'd0, pat(widx(32'h784))});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("arst_stays_idle", {63'd0, busy_o}, 64'd0);

`ifdef DMA_FILL_EN
    // Fill mode: source unchecked even when misaligned, one write per cycle.
    expect_fill(32'h40, 3, 32'hDEADBEEF);
    run(32'h3, 32'h40, 16'd3, 1'b1, 32'hDEADBEEF, 99, 0, 99, 99, 8);
    check("fill_done_cyc", 64'(r_done_cyc), 64'd4);
    check("fill_no_err", 64'(r_n_err), 64'd0);
    check("fill_q_empty", 64'(exp_q.size()), 64'd0);
    check("fill_lit0", {32'd0, mem[32'h10]}, 64'hDEADBEEF);
    check("fill_lit2", {32'd0, mem[32'h12]}, 64'hDEADBEEF);
    check("fill_untouched", {32'd0, mem[32'h13]}, {32'd0, pat(32'h13)});
    fill_i = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
